// File: rtl/seq_mon_pkg.sv
// seq_mon_pkg: shared types and helpers for the seq_monitor block.
//   seq_state_e : per-channel monitor state (IDLE, ARMED)
//   sat_inc     : saturating increment for counters up to 32 bits wide
//   params_ok   : parameter legality check, evaluated as a constant at elaboration
package seq_mon_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } seq_state_e;

  localparam int unsigned MAX_NUM_CH = 32;
  localparam int unsigned MAX_WINDOW = 255;
  localparam int unsigned MAX_CNT_W  = 32;

  // Increments val unless it already holds the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : (val + 32'd1);
  endfunction

  function automatic bit params_ok(input int unsigned num_ch, input int unsigned min_dly,
                                   input int unsigned max_dly, input int unsigned cnt_w);
    return (num_ch >= 1) && (num_ch <= MAX_NUM_CH) &&
           (min_dly >= 1) && (min_dly <= max_dly) && (max_dly <= MAX_WINDOW) &&
           (cnt_w >= 1) && (cnt_w <= MAX_CNT_W);
  endfunction

endpackage

// File: rtl/seq_mon_ch.sv
// seq_mon_ch: one channel of the bounded-implication monitor
//   a && b |-> ##[MIN_DLY:MAX_DLY] d
// Optional feature macro: SEQ_MON_STICKY_EN (adds fail_sticky).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                enable; low aborts any attempt and holds the channel IDLE
//   clear             zeroes counters (and sticky flag)
//   a, b, d           antecedent terms and consequent
//   busy              attempt in flight
//   pass, fail        one-cycle result pulses
//   pass_cnt/fail_cnt saturating result counters
//   fail_sticky       (optional) latched fail indication
//
// state | meaning
// IDLE  | waiting for a && b
// ARMED | attempt in flight; dly counts edges since arming
module seq_mon_ch
  import seq_mon_pkg::*;
#(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             a,
  input  logic             b,
  input  logic             d,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef SEQ_MON_STICKY_EN
  ,
  output logic             fail_sticky
`endif
);

  localparam int unsigned DLY_W = $clog2(MAX_DLY + 1);
  localparam logic [DLY_W-1:0] MIN_K = DLY_W'(MIN_DLY);
  localparam logic [DLY_W-1:0] MAX_K = DLY_W'(MAX_DLY);

  seq_state_e       state_q, state_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             resolved;
  logic             antecedent;

  assign antecedent = a && b;

  always_comb begin
    state_d  = state_q;
    dly_d    = dly_q;
    pass_d   = 1'b0;
    fail_d   = 1'b0;
    resolved = 1'b0;
    if (!en) begin
      state_d = IDLE;
      dly_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (antecedent) begin
            state_d = ARMED;
            dly_d   = DLY_W'(1);
          end
        end
        ARMED: begin
          if (d && (dly_q >= MIN_K)) begin
            pass_d   = 1'b1;
            resolved = 1'b1;
          end else if (dly_q == MAX_K) begin
            fail_d   = 1'b1;
            resolved = 1'b1;
          end else begin
            dly_d = dly_q + DLY_W'(1);
          end
          // A fresh antecedent on the resolving edge starts the next attempt immediately.
          if (resolved) begin
            if (antecedent) begin
              state_d = ARMED;
              dly_d   = DLY_W'(1);
            end else begin
              state_d = IDLE;
              dly_d   = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          dly_d   = '0;
        end
      endcase
    end
  end

  // clear wins over a same-edge increment.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_d) pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_W));
      if (fail_d) fail_cnt_d = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      dly_q      <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy     = (state_q == ARMED);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

`ifdef SEQ_MON_STICKY_EN
  logic sticky_q, sticky_d;

  // Set beats clear when both land on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (fail_d)     sticky_d = 1'b1;
    else if (clear) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign fail_sticky = sticky_q;
`endif

endmodule

// File: rtl/seq_monitor.sv
// seq_monitor: NUM_CH independent bounded-implication monitors
//   a && b |-> ##[MIN_DLY:MAX_DLY] d
// Optional feature macro: SEQ_MON_STICKY_EN (adds fail_sticky output).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en                global enable
//   clear             synchronous counter/sticky clear
//   a, b, d           per-channel antecedent terms and consequent
//   busy, pass, fail  per-channel status and one-cycle result pulses
//   pass_cnt/fail_cnt packed saturating counters, channel i at [i*CNT_W +: CNT_W]
//   fail_sticky       (optional) per-channel latched fail
module seq_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       a,
  input  logic [NUM_CH-1:0]       b,
  input  logic [NUM_CH-1:0]       d,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       pass,
  output logic [NUM_CH-1:0]       fail,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt
`ifdef SEQ_MON_STICKY_EN
  ,
  output logic [NUM_CH-1:0]       fail_sticky
`endif
);

  localparam bit PARAMS_OK = params_ok(NUM_CH, MIN_DLY, MAX_DLY, CNT_W);

  if (!PARAMS_OK) begin : g_param_err
    $error("seq_monitor: illegal NUM_CH/MIN_DLY/MAX_DLY/CNT_W combination");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    seq_mon_ch #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .clear       (clear),
      .a           (a[i]),
      .b           (b[i]),
      .d           (d[i]),
      .busy        (busy[i]),
      .pass        (pass[i]),
      .fail        (fail[i]),
      .pass_cnt    (pass_cnt[i*CNT_W +: CNT_W]),
      .fail_cnt    (fail_cnt[i*CNT_W +: CNT_W])
`ifdef SEQ_MON_STICKY_EN
      ,
      .fail_sticky (fail_sticky[i])
`endif
    );
  end

endmodule

// File: tb/tb_seq_monitor.sv
module tb_seq_monitor;

  logic        clk = 1'b0;
  logic        rst, en, clear, clear2;
  logic [3:0]  a, b, d;
  logic [3:0]  busy, pass, fail;
  logic [63:0] pass_cnt, fail_cnt;
  logic [0:0]  a2, b2, d2;
  logic [0:0]  busy2, pass2, fail2;
  logic [1:0]  pass_cnt2, fail_cnt2;
`ifdef SEQ_MON_STICKY_EN
  logic [3:0]  sticky;
  logic [0:0]  sticky2;
`endif

  int tests  = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_monitor u_dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (clear),
    .a        (a),
    .b        (b),
    .d        (d),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt)
`ifdef SEQ_MON_STICKY_EN
    ,
    .fail_sticky (sticky)
`endif
  );

  seq_monitor #(.NUM_CH(1), .MIN_DLY(2), .MAX_DLY(3), .CNT_W(2)) u_dut2 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (clear2),
    .a        (a2),
    .b        (b2),
    .d        (d2),
    .busy     (busy2),
    .pass     (pass2),
    .fail     (fail2),
    .pass_cnt (pass_cnt2),
    .fail_cnt (fail_cnt2)
`ifdef SEQ_MON_STICKY_EN
    ,
    .fail_sticky (sticky2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clear = 1'b0; clear2 = 1'b0;
    a = '0; b = '0; d = '0; a2 = '0; b2 = '0; d2 = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_busy",     64'(busy),     64'h0);
    check("rst_pass",     64'(pass),     64'h0);
    check("rst_fail",     64'(fail),     64'h0);
    check("rst_pass_cnt", pass_cnt,      64'h0);
    check("rst_fail_cnt", fail_cnt,      64'h0);
    check("rst_busy2",    64'(busy2),    64'h0);
    check("rst_fcnt2",    64'(fail_cnt2),64'h0);

    // Channel 0: arm, d at E2 -> pass
    a = 4'b0001; b = 4'b0001; tick(); a = '0; b = '0;
    check("s1_busy_e0", 64'(busy), 64'h1);
    tick();
    check("s1_busy_e1", 64'(busy), 64'h1);
    check("s1_nopass_e1", 64'(pass), 64'h0);
    d = 4'b0001; tick(); d = '0;
    check("s1_pass", 64'(pass), 64'h1);
    check("s1_pass_cnt", pass_cnt, 64'h0000_0000_0000_0001);
    check("s1_busy_after", 64'(busy), 64'h0);
    tick();
    check("s1_pulse_end", 64'(pass), 64'h0);

    // Channel 1: no consequent -> fail at E3
    a = 4'b0010; b = 4'b0010; tick(); a = '0; b = '0;
    tick(); tick();
    check("s2_nofail_e2", 64'(fail), 64'h0);
    check("s2_busy_e2", 64'(busy), 64'h2);
    tick();
    check("s2_fail", 64'(fail), 64'h2);
    check("s2_fail_cnt", fail_cnt, 64'h0000_0000_0001_0000);
    check("s2_pass_cnt_kept", pass_cnt, 64'h0000_0000_0000_0001);
`ifdef SEQ_MON_STICKY_EN
    check("s2_sticky", 64'(sticky), 64'h2);
`endif
    tick();
    check("s2_pulse_end", 64'(fail), 64'h0);

    // Channel 2: d in antecedent cycle ignored, antecedent while armed ignored,
    // pass at E3 with new antecedent re-arms
    a = 4'b0100; b = 4'b0100; d = 4'b0100; tick();
    check("s4_early_d", 64'(pass), 64'h0);
    check("s4_busy_e0", 64'(busy), 64'h4);
    d = '0; tick();
    a = '0; b = '0; tick();
    a = 4'b0100; b = 4'b0100; d = 4'b0100; tick();
    a = '0; b = '0; d = '0;
    check("s4_pass", 64'(pass), 64'h4);
    check("s4_pass_cnt", pass_cnt, 64'h0000_0001_0000_0001);
    check("s4_rearmed", 64'(busy), 64'h4);
    tick(); tick();
    check("s4_nofail_e2", 64'(fail), 64'h0);
    tick();
    check("s4_fail_rearm", 64'(fail), 64'h4);
    check("s4_fail_cnt", fail_cnt, 64'h0000_0001_0001_0000);
    check("s4_idle", 64'(busy), 64'h0);

    // clear: zeroes counters, leaves FSMs running; wins over same-edge pass
    a = 4'b0001; b = 4'b0001; clear = 1'b1; tick();
    a = '0; b = '0; clear = 1'b0;
    check("clr_pass_cnt", pass_cnt, 64'h0);
    check("clr_fail_cnt", fail_cnt, 64'h0);
    check("clr_busy_kept", 64'(busy), 64'h1);
    d = 4'b0001; tick(); d = '0;
    check("clr_pass_after", 64'(pass), 64'h1);
    check("clr_cnt_after", pass_cnt, 64'h0000_0000_0000_0001);
    a = 4'b0001; b = 4'b0001; tick(); a = '0; b = '0;
    d = 4'b0001; clear = 1'b1; tick(); d = '0; clear = 1'b0;
    check("clr_prio_pulse", 64'(pass), 64'h1);
    check("clr_prio_cnt", pass_cnt, 64'h0);
`ifdef SEQ_MON_STICKY_EN
    check("clr_sticky", 64'(sticky), 64'h0);
`endif

    // Simultaneous fails on channels 0 and 3
    a = 4'b1001; b = 4'b1001; tick(); a = '0; b = '0;
    tick(); tick(); tick();
    check("multi_fail", 64'(fail), 64'h9);
    check("multi_fail_cnt", fail_cnt, 64'h0001_0000_0000_0001);

    // MIN_DLY=2 instance: d at E1 too early -> fail at E3, re-arm on same edge
    a2 = 1'b1; b2 = 1'b1; tick(); a2 = 1'b0; b2 = 1'b0;
    d2 = 1'b1; tick(); d2 = 1'b0;
    check("s3_early_d", 64'(pass2), 64'h0);
    tick();
    a2 = 1'b1; b2 = 1'b1; tick(); a2 = 1'b0; b2 = 1'b0;
    check("s3_fail", 64'(fail2), 64'h1);
    check("s3_rearm_busy", 64'(busy2), 64'h1);
    check("s3_fail_cnt", 64'(fail_cnt2), 64'h1);

    // Saturation of a 2-bit counter over fails 2..5
    for (int k = 2; k <= 5; k++) begin
      tick(); tick();
      a2 = 1'b1; b2 = 1'b1; tick(); a2 = 1'b0; b2 = 1'b0;
      check($sformatf("s5_fail_%0d", k), 64'(fail2), 64'h1);
      check($sformatf("s5_cnt_%0d", k), 64'(fail_cnt2), (k > 3) ? 64'h3 : 64'(k));
    end
    // Sixth fail with clear on the same edge
    tick(); tick();
    a2 = 1'b1; b2 = 1'b1; clear2 = 1'b1; tick();
    a2 = 1'b0; b2 = 1'b0; clear2 = 1'b0;
    check("s5_fail6", 64'(fail2), 64'h1);
    check("s5_clear_cnt", 64'(fail_cnt2), 64'h0);
`ifdef SEQ_MON_STICKY_EN
    check("s5_sticky_set_wins", 64'(sticky2), 64'h1);
`endif
    // Still armed: d at E2 passes (k == MIN_DLY)
    tick();
    d2 = 1'b1; tick(); d2 = 1'b0;
    check("s3_pass_min", 64'(pass2), 64'h1);
    check("s3_pass_cnt", 64'(pass_cnt2), 64'h1);
    check("s3_idle", 64'(busy2), 64'h0);
`ifdef SEQ_MON_STICKY_EN
    check("s5_sticky_hold", 64'(sticky2), 64'h1);
    clear2 = 1'b1; tick(); clear2 = 1'b0;
    check("s5_sticky_clear", 64'(sticky2), 64'h0);
`endif

    // Reset at E2 of an armed attempt
    a = 4'b1000; b = 4'b1000; tick(); a = '0; b = '0;
    tick();
    check("s6_busy_pre", 64'(busy), 64'h8);
    rst = 1'b1; d = 4'b1000; tick(); rst = 1'b0; d = '0;
    check("s6_rst_busy", 64'(busy), 64'h0);
    check("s6_rst_pass", 64'(pass), 64'h0);
    check("s6_rst_fail", 64'(fail), 64'h0);
    check("s6_rst_fcnt", fail_cnt, 64'h0);
    tick();
    check("s6_no_late_pass", 64'(pass), 64'h0);

    // en=0 at E1 aborts the attempt
    a = 4'b1000; b = 4'b1000; tick(); a = '0; b = '0;
    en = 1'b0; d = 4'b1000; tick(); en = 1'b1;
    check("s6_en_busy", 64'(busy), 64'h0);
    check("s6_en_pass", 64'(pass), 64'h0);
    tick(); d = '0; tick(); tick();
    check("s6_en_nofail", 64'(fail), 64'h0);
    check("s6_en_pcnt", pass_cnt, 64'h0);
    check("s6_en_fcnt", fail_cnt, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/seq_monitor.md
# seq_monitor

Synthesizable multi-channel sequence monitor implementing the bounded implication `a && b |-> ##[MIN_DLY:MAX_DLY] d` per channel.

- Sits beside a DUT in simulation benches and on FPGA builds, where SVA is unavailable.
- Reports one-cycle pass/fail pulses and saturating per-channel pass/fail counters, so benches and on-chip debug read identical results.
- Generalises the single-channel, fixed-window check to `NUM_CH` channels with a parametrised window and counter width.

## Interface

Parameters:

- `NUM_CH`, 4, number of independent monitor channels (1..32).
- `MIN_DLY`, 1, earliest cycle after the antecedent at which `d` satisfies the check (≥1).
- `MAX_DLY`, 3, last cycle of the window (`MIN_DLY` ≤ `MAX_DLY` ≤ 255).
- `CNT_W`, 16, width of each pass/fail counter.

Ports:

- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: global enable.
- `clear` input 1: synchronous clear of counters (and sticky flags).
- `a` input NUM_CH: antecedent term A per channel.
- `b` input NUM_CH: antecedent term B per channel.
- `d` input NUM_CH: consequent per channel.
- `busy` output NUM_CH: channel has an attempt in flight.
- `pass` output NUM_CH: one-cycle pulse when an attempt succeeds.
- `fail` output NUM_CH: one-cycle pulse when an attempt expires.
- `pass_cnt` output NUM_CH*CNT_W: packed saturating pass counters; channel i occupies bits [i*CNT_W +: CNT_W].
- `fail_cnt` output NUM_CH*CNT_W: packed saturating fail counters, same packing as `pass_cnt`.
- `fail_sticky` output NUM_CH: present only with `SEQ_MON_STICKY_EN`.

## Operation

Each channel runs an FSM with two states, IDLE and ARMED, plus a delay counter `dly` of width $clog2(MAX_DLY+1).

- **IDLE:**
  - On an edge with `en && a[i] && b[i]`, go to ARMED with `dly=1`. Edges are numbered from here: the arming edge is E0, the next is E1.
  - Otherwise stay in IDLE.
- **ARMED, at edge Ek (k = `dly`):**
  - If `d[i]` and k ≥ `MIN_DLY`: pass. Set `pass[i]`, increment `pass_cnt`.
  - Else if k == `MAX_DLY`: fail. Set `fail[i]`, increment `fail_cnt`.
  - Else: `dly++` and stay in ARMED.
- **Early consequent:** `d[i]` high before `MIN_DLY`, or in the antecedent cycle itself, is ignored.
- **Non-overlapping attempts:** an antecedent that arrives while ARMED is ignored, except at the resolving edge (see below).
- **Resolving edge with a new antecedent:** when a pass or fail resolves at an edge where `a[i] && b[i]` also holds, the result is reported and the channel re-arms with `dly=1`.
- `busy[i]` is 1 exactly when the channel is in ARMED.
- **`en`:**
  - `en=0` forces every channel to IDLE at the next edge.
  - Any in-flight attempt is aborted with no pass/fail and no count.
- **Counters:**
  - Saturate at all-ones; no wrap.
  - `clear=1` zeroes all counters at that edge and takes priority over a same-edge increment.
  - `clear` does not affect FSMs, `pass` or `fail`.
- **Channels** are fully independent; simultaneous results on several channels are all reported and counted in the same cycle.

## Timing

- **Reset values** (after `rst` high at an edge): FSMs IDLE, `busy`=0, `pass`=0, `fail`=0, all counters 0, `fail_sticky`=0.
- **Reset mid-attempt:** the attempt is discarded with no result.
- **`rst` priority:** over `en` and `clear`.
- **Output registration:** all outputs are registered.
- **`pass`/`fail` pulses:** high for exactly the one cycle following the resolving edge.
- **Counter update:** counters reflect the result in the same cycle as the pulse.
- **Latency:**
  - Pass is reported at edge E`MIN_DLY`..E`MAX_DLY`.
  - Fail is reported at edge E`MAX_DLY`.
- **Re-arm spacing:** a channel can re-arm at its resolving edge, so the worst-case sustained rate is one result per `MIN_DLY` cycles.

## Configuration

- Macro: `SEQ_MON_STICKY_EN`.
- **Defined:**
  - Adds the `fail_sticky` output.
  - `fail_sticky[i]` sets on any fail of channel i and holds until `clear` or `rst`.
  - If a fail and `clear` occur at the same edge, set wins.
- **Undefined:** the port and its logic are absent; nothing else changes.

## Structure

- **Package `seq_mon_pkg`:**
  - `seq_state_e` enum (IDLE, ARMED).
  - Saturating-increment function `sat_inc`.
  - Parameter-legality checks expressed as constants.
- **Sub-module `seq_mon_ch`:** one channel (FSM, `dly`, two counters, optional sticky flag).
- **Top level:** instantiates `NUM_CH` copies in a generate loop and packs the outputs.

## Test plan

All scenarios use the defaults (`MIN_DLY`=1, `MAX_DLY`=3) unless noted.

1. `a[0]=b[0]=1` at E0, `d[0]=1` at E2 → `pass[0]` high one cycle after E2, `pass_cnt[0]=1`, `busy[0]` high E0..E2.
2. `a[1]=b[1]=1` at E0, `d[1]=0` at E1..E3 → `fail[1]` pulse after E3, `fail_cnt[1]=1`, other channels unchanged.
3. `MIN_DLY=2`: antecedent at E0, `d=1` only at E1 → no pass, fail after E3; antecedent again at E3 → re-armed, `busy` stays 1.
4. Antecedent at E0 and E1, `d` at E3 with antecedent also at E3 → one pass, `pass_cnt=1`, channel ARMED again after E3.
5. `CNT_W=2`: five consecutive fails → `fail_cnt=3`; `clear` at the same edge as the sixth fail → `fail_cnt=0`; with `SEQ_MON_STICKY_EN`, `fail_sticky=1`.
6. `rst` at E2 of an armed attempt → all outputs 0, no pulse; separately, `en=0` at E1 → no result and `busy=0` after E1.
